// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings,
// the NOP and halt instruction words, and the default sequential PC increment.
package instruction_fetch_unit_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_STEP = 2'd2;
   localparam logic [1:0] ST_HALT = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      STEP = ST_STEP,
      HALT = ST_HALT
   } fetch_state_t;

   localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
   localparam logic [31:0] PC_STEP_DEFAULT   = 32'd4;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Control, redirect, memory and IF/ID signals of the fetch unit.
// master is the fetch unit itself; slave is the surrounding pipeline/debug logic.
interface instruction_fetch_unit_if #(
   parameter int NBITS = 32
);
   logic             i_enable;
   logic             i_mode;
   logic             i_step;
   logic             i_stall;
   logic             i_flush;
   logic             i_branch_taken;
   logic [NBITS-1:0] i_branch_target;
   logic             i_jump;
   logic [NBITS-1:0] i_jump_target;
   logic [NBITS-1:0] i_instruction;
   logic [NBITS-1:0] o_pc;
   logic [NBITS-1:0] o_ifid_instruction;
   logic [NBITS-1:0] o_ifid_pc_plus4;
   logic             o_ifid_valid;
   logic             o_halted;
   logic [NBITS-1:0] o_cycle_count;

   modport master (
      input  i_enable, i_mode, i_step, i_stall, i_flush,
      input  i_branch_taken, i_branch_target, i_jump, i_jump_target, i_instruction,
      output o_pc, o_ifid_instruction, o_ifid_pc_plus4, o_ifid_valid, o_halted, o_cycle_count
   );

   modport slave (
      output i_enable, i_mode, i_step, i_stall, i_flush,
      output i_branch_taken, i_branch_target, i_jump, i_jump_target, i_instruction,
      input  o_pc, o_ifid_instruction, o_ifid_pc_plus4, o_ifid_valid, o_halted, o_cycle_count
   );
endinterface

// File: rtl/instruction_fetch_unit_pc_next_select.sv
// Next-PC priority mux: jump beats branch beats sequential; all arithmetic wraps.
module instruction_fetch_unit_pc_next_select #(
   parameter int               NBITS   = 32,
   parameter logic [NBITS-1:0] PC_STEP = NBITS'(4)
) (
   input  logic [NBITS-1:0] pc,
   input  logic             jump,
   input  logic [NBITS-1:0] jump_target,
   input  logic             branch_taken,
   input  logic [NBITS-1:0] branch_target,
   output logic [NBITS-1:0] next_pc,
   output logic [NBITS-1:0] pc_plus4
);

   assign pc_plus4 = pc + PC_STEP;

   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = jump_target;
      end else if (branch_taken) begin
         next_pc = branch_target;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF-stage controller: owns the PC, latches the IF/ID register and gates fetch
// through run / single-step / halt debug control.
//
// state | meaning
// IDLE  | fetch frozen, waiting for enable
// RUN   | one fetch per cycle
// STEP  | one fetch per rising edge of i_step
// HALT  | halt word fetched; only reset leaves
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int               NBITS     = 32,
   parameter logic [NBITS-1:0] RESET_PC  = NBITS'(4),
   parameter logic [NBITS-1:0] PC_STEP   = NBITS'(PC_STEP_DEFAULT),
   parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_WORD_DEFAULT)
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   instruction_fetch_unit_if.master bus
);

   localparam logic [NBITS-1:0] NOP = NBITS'(NOP_WORD);

   fetch_state_t     state_q, state_d;
   logic             step_q;
   logic [NBITS-1:0] pc_q;
   logic [NBITS-1:0] ifid_instr_q;
   logic [NBITS-1:0] ifid_p4_q;
   logic             ifid_valid_q;
   logic [NBITS-1:0] cycle_cnt_q;
   logic             advance;
   logic             halt_hit;
   logic [NBITS-1:0] next_pc;
   logic [NBITS-1:0] pc_plus4;

   instruction_fetch_unit_pc_next_select #(
      .NBITS   (NBITS),
      .PC_STEP (PC_STEP)
   ) u_pc_next_select (
      .pc            (pc_q),
      .jump          (bus.i_jump),
      .jump_target   (bus.i_jump_target),
      .branch_taken  (bus.i_branch_taken),
      .branch_target (bus.i_branch_target),
      .next_pc       (next_pc),
      .pc_plus4      (pc_plus4)
   );

   always_comb begin
      state_d  = state_q;
      advance  = 1'b0;
      case (state_q)
         IDLE: if (bus.i_enable) state_d = bus.i_mode ? STEP : RUN;
         RUN:  advance = 1'b1;
         STEP: advance = bus.i_step & ~step_q;
         HALT: advance = 1'b0;
         default: state_d = IDLE;
      endcase
      halt_hit = advance & ~bus.i_flush & ~bus.i_stall & (bus.i_instruction == HALT_WORD);
      // A halt word fetched on the same cycle enable drops still wins.
      if (state_q == RUN || state_q == STEP) begin
         if (halt_hit) begin
            state_d = HALT;
         end else if (!bus.i_enable) begin
            state_d = IDLE;
         end else begin
            state_d = bus.i_mode ? STEP : RUN;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q      <= IDLE;
         step_q       <= 1'b0;
         pc_q         <= RESET_PC;
         ifid_instr_q <= NOP;
         ifid_p4_q    <= '0;
         ifid_valid_q <= 1'b0;
         cycle_cnt_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= bus.i_step;
         // Drain the halt word downstream once, then IF/ID sits at NOP.
         if (state_q == HALT) begin
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
         end else if (advance) begin
            if (cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + NBITS'(1);
            if (bus.i_flush) begin
               ifid_instr_q <= NOP;
               ifid_valid_q <= 1'b0;
               pc_q         <= next_pc;
            end else if (!bus.i_stall) begin
               ifid_instr_q <= bus.i_instruction;
               ifid_p4_q    <= pc_plus4;
               ifid_valid_q <= 1'b1;
               if (!halt_hit) pc_q <= next_pc;
            end
         end
      end
   end

   assign bus.o_pc               = pc_q;
   assign bus.o_ifid_instruction = ifid_instr_q;
   assign bus.o_ifid_pc_plus4    = ifid_p4_q;
   assign bus.o_ifid_valid       = ifid_valid_q;
   assign bus.o_halted           = (state_q == HALT);
   assign bus.o_cycle_count      = cycle_cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Table-driven bench for instruction_fetch_unit with a queue-based scoreboard
// and a combinational instruction memory model.
module tb_instruction_fetch_unit;

   localparam logic [31:0] HALT_PC = 32'd156;

   typedef struct {
      logic [6:0]  ctl;   // {en, mode, step, stall, flush, br, jmp}
      logic [31:0] brt;
      logic [31:0] jt;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
      logic [31:0] e_p4;
      logic        e_val;
      logic        e_halt;
      logic [31:0] e_cnt;
   } vec_t;

   logic i_clk;
   logic i_reset;
   int   checks;
   int   errors;
   vec_t tab[$];
   vec_t exp_q[$];

   instruction_fetch_unit_if #(.NBITS(32)) bus ();

   instruction_fetch_unit #(.NBITS(32)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'd0 || a == HALT_PC) return 32'hFFFF_FFFF;
      return 32'h2000_0000 | a;
   endfunction

   assign bus.i_instruction = mem_word(bus.o_pc);

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   function automatic vec_t mk(input logic [6:0] ctl, input logic [31:0] brt, jt, pc, ins, p4,
                               input logic val, halt, input logic [31:0] cnt);
      vec_t v;
      v.ctl = ctl; v.brt = brt; v.jt = jt;
      v.e_pc = pc; v.e_ins = ins; v.e_p4 = p4;
      v.e_val = val; v.e_halt = halt; v.e_cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic apply_row(input string tag, input int idx, input vec_t v);
      vec_t e;
      bus.i_enable        = v.ctl[6];
      bus.i_mode          = v.ctl[5];
      bus.i_step          = v.ctl[4];
      bus.i_stall         = v.ctl[3];
      bus.i_flush         = v.ctl[2];
      bus.i_branch_taken  = v.ctl[1];
      bus.i_jump          = v.ctl[0];
      bus.i_branch_target = v.brt;
      bus.i_jump_target   = v.jt;
      exp_q.push_back(v);
      @(posedge i_clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("%s%0d pc", tag, idx),    bus.o_pc,                   e.e_pc);
      chk($sformatf("%s%0d ifid", tag, idx),  bus.o_ifid_instruction,     e.e_ins);
      chk($sformatf("%s%0d p4", tag, idx),    bus.o_ifid_pc_plus4,        e.e_p4);
      chk($sformatf("%s%0d valid", tag, idx), 32'(bus.o_ifid_valid),      32'(e.e_val));
      chk($sformatf("%s%0d halted", tag, idx), 32'(bus.o_halted),         32'(e.e_halt));
      chk($sformatf("%s%0d cnt", tag, idx),   bus.o_cycle_count,          e.e_cnt);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, " pc"},     bus.o_pc,                 32'd4);
      chk({tag, " ifid"},   bus.o_ifid_instruction,   32'd0);
      chk({tag, " p4"},     bus.o_ifid_pc_plus4,      32'd0);
      chk({tag, " valid"},  32'(bus.o_ifid_valid),    32'd0);
      chk({tag, " halted"}, 32'(bus.o_halted),        32'd0);
      chk({tag, " cnt"},    bus.o_cycle_count,        32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      i_reset = 1'b1;
      bus.i_enable = 0; bus.i_mode = 0; bus.i_step = 0; bus.i_stall = 0; bus.i_flush = 0;
      bus.i_branch_taken = 0; bus.i_jump = 0; bus.i_branch_target = 0; bus.i_jump_target = 0;
      #1 i_reset = 1'b0;
      #1 check_reset_values("reset");
      #10 i_reset = 1'b1;

      // run, stall, redirect/flush, enable drop, single-step, halt
      tab.push_back(mk(7'b1000000, 0, 0,   32'd4,   32'h0,         32'd0,   0, 0, 0));
      tab.push_back(mk(7'b1000000, 0, 0,   32'd8,   32'h2000_0004, 32'd8,   1, 0, 1));
      tab.push_back(mk(7'b1000000, 0, 0,   32'd12,  32'h2000_0008, 32'd12,  1, 0, 2));
      tab.push_back(mk(7'b1000000, 0, 0,   32'd16,  32'h2000_000C, 32'd16,  1, 0, 3));
      tab.push_back(mk(7'b1000000, 0, 0,   32'd20,  32'h2000_0010, 32'd20,  1, 0, 4));
      tab.push_back(mk(7'b1001000, 0, 0,   32'd20,  32'h2000_0010, 32'd20,  1, 0, 5));
      tab.push_back(mk(7'b1001000, 0, 0,   32'd20,  32'h2000_0010, 32'd20,  1, 0, 6));
      tab.push_back(mk(7'b1001000, 0, 0,   32'd20,  32'h2000_0010, 32'd20,  1, 0, 7));
      tab.push_back(mk(7'b1000000, 0, 0,   32'd24,  32'h2000_0014, 32'd24,  1, 0, 8));
      tab.push_back(mk(7'b1000001, 0, 56,  32'd56,  32'h2000_0018, 32'd28,  1, 0, 9));
      tab.push_back(mk(7'b1001110, 72, 0,  32'd72,  32'h0,         32'd28,  0, 0, 10));
      tab.push_back(mk(7'b1000011, 200, 96, 32'd96, 32'h2000_0048, 32'd76,  1, 0, 11));
      tab.push_back(mk(7'b1000000, 0, 0,   32'd100, 32'h2000_0060, 32'd100, 1, 0, 12));
      tab.push_back(mk(7'b0000000, 0, 0,   32'd104, 32'h2000_0064, 32'd104, 1, 0, 13));
      tab.push_back(mk(7'b0000000, 0, 0,   32'd104, 32'h2000_0064, 32'd104, 1, 0, 13));
      tab.push_back(mk(7'b0000001, 0, 500, 32'd104, 32'h2000_0064, 32'd104, 1, 0, 13));
      tab.push_back(mk(7'b1100000, 0, 0,   32'd104, 32'h2000_0064, 32'd104, 1, 0, 13));
      tab.push_back(mk(7'b1110000, 0, 0,   32'd108, 32'h2000_0068, 32'd108, 1, 0, 14));
      for (int k = 0; k < 4; k++)
         tab.push_back(mk(7'b1110000, 0, 0, 32'd108, 32'h2000_0068, 32'd108, 1, 0, 14));
      tab.push_back(mk(7'b1100000, 0, 0,   32'd108, 32'h2000_0068, 32'd108, 1, 0, 14));
      tab.push_back(mk(7'b1110000, 0, 0,   32'd112, 32'h2000_006C, 32'd112, 1, 0, 15));
      tab.push_back(mk(7'b1100000, 0, 0,   32'd112, 32'h2000_006C, 32'd112, 1, 0, 15));
      tab.push_back(mk(7'b1110000, 0, 0,   32'd116, 32'h2000_0070, 32'd116, 1, 0, 16));
      tab.push_back(mk(7'b0000000, 0, 0,   32'd116, 32'h2000_0070, 32'd116, 1, 0, 16));
      tab.push_back(mk(7'b0010000, 0, 0,   32'd116, 32'h2000_0070, 32'd116, 1, 0, 16));
      tab.push_back(mk(7'b1110000, 0, 0,   32'd116, 32'h2000_0070, 32'd116, 1, 0, 16));
      tab.push_back(mk(7'b1110000, 0, 0,   32'd116, 32'h2000_0070, 32'd116, 1, 0, 16));
      tab.push_back(mk(7'b1000000, 0, 0,   32'd116, 32'h2000_0070, 32'd116, 1, 0, 16));
      tab.push_back(mk(7'b1000000, 0, 0,   32'd120, 32'h2000_0074, 32'd120, 1, 0, 17));
      tab.push_back(mk(7'b1000001, 0, 156, 32'd156, 32'h2000_0078, 32'd124, 1, 0, 18));
      tab.push_back(mk(7'b1001000, 0, 0,   32'd156, 32'h2000_0078, 32'd124, 1, 0, 19));
      tab.push_back(mk(7'b1000100, 0, 0,   32'd160, 32'h0,         32'd124, 0, 0, 20));
      tab.push_back(mk(7'b1000001, 0, 156, 32'd156, 32'h2000_00A0, 32'd164, 1, 0, 21));
      tab.push_back(mk(7'b1000000, 0, 0,   32'd156, 32'hFFFF_FFFF, 32'd160, 1, 1, 22));
      tab.push_back(mk(7'b1000000, 0, 0,   32'd156, 32'h0,         32'd160, 0, 1, 22));
      tab.push_back(mk(7'b1110000, 0, 0,   32'd156, 32'h0,         32'd160, 0, 1, 22));
      tab.push_back(mk(7'b0000000, 0, 0,   32'd156, 32'h0,         32'd160, 0, 1, 22));
      tab.push_back(mk(7'b1000001, 0, 8,   32'd156, 32'h0,         32'd160, 0, 1, 22));
      for (int i = 0; i < tab.size(); i++) apply_row("main", i, tab[i]);

      // reset asserted between edges while running at pc=40
      i_reset = 1'b0;
      #4 i_reset = 1'b1;
      tab.delete();
      tab.push_back(mk(7'b1000000, 0, 0,   32'd4,  32'h0,         32'd0, 0, 0, 0));
      tab.push_back(mk(7'b1000001, 0, 40,  32'd40, 32'h2000_0004, 32'd8, 1, 0, 1));
      for (int i = 0; i < tab.size(); i++) apply_row("mid", i, tab[i]);
      #3 i_reset = 1'b0;
      #1 check_reset_values("async_reset");
      #1 i_reset = 1'b1;

      // PC wraps to 0, where the halt sentinel lives
      tab.delete();
      tab.push_back(mk(7'b1000000, 0, 0,            32'd4,          32'h0,         32'd0, 0, 0, 0));
      tab.push_back(mk(7'b1000001, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h2000_0004, 32'd8, 1, 0, 1));
      tab.push_back(mk(7'b1000000, 0, 0,            32'd0,          32'hFFFF_FFFC, 32'd0, 1, 0, 2));
      tab.push_back(mk(7'b1000000, 0, 0,            32'd0,          32'hFFFF_FFFF, 32'd4, 1, 1, 3));
      for (int i = 0; i < tab.size(); i++) apply_row("wrap", i, tab[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
